// File: rtl/msg_transmit_scheduler.sv
// Round-robin scheduler sharing one framer between CH_NUM byte FIFOs.
// Channels request on fill level or age; the grant steers FIFO and header fields to the framer.
module msg_transmit_scheduler #(
  parameter int          CH_NUM        = 4,
  parameter logic [15:0] FLUSH_LEN     = 16'd1008,
  parameter logic [19:0] FLUSH_TIMEOUT = 20'd100000,
  parameter logic [7:0]  GAP_CYCLES    = 8'd4,
  parameter logic [23:0] WDOG_CYCLES   = 24'd1000000
) (
  input  logic                   sys_clk_i,
  input  logic                   rst_n_i,
  input  logic                   enable_i,
  input  logic [16*CH_NUM-1:0]   ch_data_count_i,
  input  logic [CH_NUM-1:0]      ch_empty_i,
  input  logic [8*CH_NUM-1:0]    ch_din_i,
  output logic [CH_NUM-1:0]      ch_rd_en_o,
  output logic                   drv_start_pluse_o,
  input  logic                   drv_send_done_i,
  input  logic                   drv_rd_en_i,
  output logic [7:0]             drv_din_o,
  output logic [15:0]            drv_data_count_o,
  output logic                   drv_empty_o,
  output logic [15:0]            drv_frame_cnt_o,
  output logic [7:0]             drv_data_channel_o,
  output logic                   busy_o,
  output logic [2:0]             active_ch_o,
  output logic                   wdog_err_o,
  input  logic                   err_clr_i
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_START,
    ST_BUSY,
    ST_GAP
  } state_t;

  state_t              state_reg, state_next;
  logic [CH_NUM-1:0]   req;
  logic [16*CH_NUM-1:0] frame_cnt_flat;
  logic [2:0]          rr_ptr_reg;
  logic [2:0]          grant_reg;
  logic [2:0]          arb_idx;
  logic                arb_found;
  logic [3:0]          cand;
  logic [15:0]         arb_frame_cnt;
  logic [23:0]         cyc_cnt_reg, cyc_cnt_next;
  logic [15:0]         frame_out_reg;
  logic [7:0]          chan_out_reg;
  logic                wdog_err_reg;
  logic                in_start, in_busy, in_gap;
  logic                done_evt, wdog_evt, gap_last;
  logic [2:0]          rr_after_grant;

  assign in_start = (state_reg == ST_START);
  assign in_busy  = (state_reg == ST_BUSY);
  assign in_gap   = (state_reg == ST_GAP);

  // The framer spends its first BUSY cycles latching the length, so early done pulses are stale.
  assign done_evt = in_busy && drv_send_done_i && (cyc_cnt_reg >= 24'd2);
  assign wdog_evt = in_busy && !done_evt && (cyc_cnt_reg >= WDOG_CYCLES - 24'd1);
  assign gap_last = (cyc_cnt_reg + 24'd1) >= {16'd0, GAP_CYCLES};
  assign rr_after_grant = (grant_reg == 3'(CH_NUM - 1)) ? 3'd0 : grant_reg + 3'd1;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : gen_ch
      logic [19:0] age_reg;
      logic [15:0] frame_cnt_reg;
      logic        granted;

      assign granted = (grant_reg == 3'(gi));

      always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          age_reg <= '0;
        end else if (ch_empty_i[gi] || (in_start && granted)) begin
          age_reg <= '0;
        end else if (age_reg < FLUSH_TIMEOUT) begin
          age_reg <= age_reg + 20'd1;
        end
      end

      always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          frame_cnt_reg <= '0;
        end else if (done_evt && granted) begin
          frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
      end

      assign req[gi] = !ch_empty_i[gi] &&
                       ((ch_data_count_i[16*gi +: 16] >= FLUSH_LEN) || (age_reg == FLUSH_TIMEOUT));
      assign frame_cnt_flat[16*gi +: 16] = frame_cnt_reg;
    end
  endgenerate

  // Scan from rr_ptr upward with wrap; first requester wins.
  always_comb begin
    arb_found     = 1'b0;
    arb_idx       = rr_ptr_reg;
    arb_frame_cnt = '0;
    cand          = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      cand = {1'b0, rr_ptr_reg} + 4'(i);
      if (cand >= 4'(CH_NUM)) cand = cand - 4'(CH_NUM);
      for (int k = 0; k < CH_NUM; k++) begin
        if (!arb_found && (cand == 4'(k)) && req[k]) begin
          arb_found = 1'b1;
          arb_idx   = cand[2:0];
        end
      end
    end
    for (int k = 0; k < CH_NUM; k++) begin
      if (arb_idx == 3'(k)) arb_frame_cnt = frame_cnt_flat[16*k +: 16];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (enable_i && (|req)) state_next = ST_ARB;
      ST_ARB:   state_next = arb_found ? ST_START : ST_IDLE;
      ST_START: state_next = ST_BUSY;
      ST_BUSY:  if (done_evt || wdog_evt) state_next = ST_GAP;
      ST_GAP:   if (gap_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    cyc_cnt_next = ((state_next == state_reg) && (in_busy || in_gap)) ? cyc_cnt_reg + 24'd1 : '0;
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= ST_IDLE;
      cyc_cnt_reg   <= '0;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      frame_out_reg <= '0;
      chan_out_reg  <= '0;
      wdog_err_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cyc_cnt_reg <= cyc_cnt_next;
      if ((state_reg == ST_ARB) && arb_found) begin
        grant_reg     <= arb_idx;
        frame_out_reg <= arb_frame_cnt;
        chan_out_reg  <= {5'd0, arb_idx};
      end
      if (done_evt || wdog_evt) rr_ptr_reg <= rr_after_grant;
      // A fresh watchdog event outranks a simultaneous clear.
      if (wdog_evt) begin
        wdog_err_reg <= 1'b1;
      end else if (err_clr_i) begin
        wdog_err_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    ch_rd_en_o       = '0;
    drv_din_o        = '0;
    drv_data_count_o = '0;
    drv_empty_o      = 1'b1;
    if (in_start || in_busy) begin
      for (int k = 0; k < CH_NUM; k++) begin
        if (grant_reg == 3'(k)) begin
          ch_rd_en_o[k]    = drv_rd_en_i;
          drv_din_o        = ch_din_i[8*k +: 8];
          drv_data_count_o = ch_data_count_i[16*k +: 16];
          drv_empty_o      = ch_empty_i[k];
        end
      end
    end
  end

  assign drv_start_pluse_o  = in_start;
  assign busy_o             = (state_reg != ST_IDLE);
  assign active_ch_o        = grant_reg;
  assign drv_frame_cnt_o    = frame_out_reg;
  assign drv_data_channel_o = chan_out_reg;
  assign wdog_err_o         = wdog_err_reg;

endmodule

// File: tb/tb_msg_transmit_scheduler.sv
// Directed bench for msg_transmit_scheduler: threshold, timeout, round-robin, mux, watchdog, reset.
module tb_msg_transmit_scheduler;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [16*CH-1:0] ch_data_count;
  logic [CH-1:0] ch_empty;
  logic [8*CH-1:0] ch_din;
  logic [CH-1:0] ch_rd_en;
  logic          drv_start;
  logic          drv_send_done;
  logic          drv_rd_en;
  logic [7:0]    drv_din;
  logic [15:0]   drv_data_count;
  logic          drv_empty;
  logic [15:0]   drv_frame_cnt;
  logic [7:0]    drv_data_channel;
  logic          busy;
  logic [2:0]    active_ch;
  logic          wdog_err;
  logic          err_clr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  msg_transmit_scheduler #(
    .CH_NUM(CH), .FLUSH_LEN(16'd1008), .FLUSH_TIMEOUT(20'd50),
    .GAP_CYCLES(8'd4), .WDOG_CYCLES(24'd100)
  ) dut (
    .sys_clk_i(clk), .rst_n_i(rst_n), .enable_i(enable),
    .ch_data_count_i(ch_data_count), .ch_empty_i(ch_empty), .ch_din_i(ch_din),
    .ch_rd_en_o(ch_rd_en), .drv_start_pluse_o(drv_start),
    .drv_send_done_i(drv_send_done), .drv_rd_en_i(drv_rd_en),
    .drv_din_o(drv_din), .drv_data_count_o(drv_data_count), .drv_empty_o(drv_empty),
    .drv_frame_cnt_o(drv_frame_cnt), .drv_data_channel_o(drv_data_channel),
    .busy_o(busy), .active_ch_o(active_ch), .wdog_err_o(wdog_err), .err_clr_i(err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [15:0] cnt, input logic emp);
    ch_data_count[16*k +: 16] = cnt;
    ch_empty[k] = emp;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (drv_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // From the START cycle: send-done on the third BUSY cycle, returns in the first GAP cycle.
  task automatic finish_frame();
    tick(); tick(); tick();
    drv_send_done = 1'b1;
    tick();
    drv_send_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (drv_empty !== 1'b1) begin n_err++; $display("FAIL rst_drv_empty: got %b want 1", drv_empty); end
    n_vec++; if (drv_start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b want 0", drv_start); end
    n_vec++; if (ch_rd_en !== 4'b0000) begin n_err++; $display("FAIL rst_rd_en: got %b want 0000", ch_rd_en); end
    n_vec++; if ({active_ch, wdog_err, drv_frame_cnt, drv_data_channel, drv_data_count} !== '0) begin
      n_err++; $display("FAIL rst_regs: got ch=%0d err=%b fc=%0d dc=%0d cnt=%0d want all 0",
                        active_ch, wdog_err, drv_frame_cnt, drv_data_channel, drv_data_count);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_round_robin();
    int exp_ch [6] = '{0, 1, 3, 0, 1, 3};
    int exp_fc [6] = '{0, 0, 0, 1, 1, 1};
    bit ok;
    set_ch(0, 16'd2000, 1'b0);
    set_ch(1, 16'd2000, 1'b0);
    set_ch(3, 16'd2000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      wait_start(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rr_start_%0d: got no start, want start pulse", i); end
      n_vec++; if (active_ch !== 3'(exp_ch[i])) begin n_err++; $display("FAIL rr_grant_%0d: got %0d want %0d", i, active_ch, exp_ch[i]); end
      n_vec++; if (drv_frame_cnt !== 16'(exp_fc[i])) begin n_err++; $display("FAIL rr_fcnt_%0d: got %0d want %0d", i, drv_frame_cnt, exp_fc[i]); end
      $display("rr frame %0d: ch=%0d frame_cnt=%0d", i, active_ch, drv_frame_cnt);
      if (i == 5) ch_empty = 4'hF;
      finish_frame();
    end
    wait_idle(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rr_idle: got busy, want idle"); end
  endtask

  task automatic test_threshold();
    bit ok;
    set_ch(2, 16'd1008, 1'b0);
    ch_din[23:16] = 8'h5A;
    tick();
    n_vec++; if (busy !== 1'b1 || drv_start !== 1'b0) begin n_err++; $display("FAIL thr_arb: got busy=%b start=%b want 1/0", busy, drv_start); end
    tick();
    n_vec++; if (drv_start !== 1'b1) begin n_err++; $display("FAIL thr_start: got %b want 1", drv_start); end
    n_vec++; if (active_ch !== 3'd2 || drv_data_channel !== 8'd2) begin n_err++; $display("FAIL thr_chan: got %0d/%0d want 2/2", active_ch, drv_data_channel); end
    n_vec++; if (drv_frame_cnt !== 16'd0) begin n_err++; $display("FAIL thr_fcnt: got %0d want 0", drv_frame_cnt); end
    n_vec++; if (drv_data_count !== 16'd1008 || drv_empty !== 1'b0) begin n_err++; $display("FAIL thr_mux: got cnt=%0d empty=%b want 1008/0", drv_data_count, drv_empty); end
    tick();
    n_vec++; if (drv_start !== 1'b0) begin n_err++; $display("FAIL thr_start_len: got %b want 0", drv_start); end
    ch_empty[2] = 1'b1;
    tick(); tick();
    drv_send_done = 1'b1;
    tick();
    drv_send_done = 1'b0;
    for (int g = 0; g < 4; g++) begin
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL thr_gap_%0d: got busy=%b want 1", g, busy); end
      tick();
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL thr_gap_end: got busy=%b want 0", busy); end
    n_vec++; if (dut.gen_ch[2].frame_cnt_reg !== 16'd1) begin n_err++; $display("FAIL thr_fcnt2: got %0d want 1", dut.gen_ch[2].frame_cnt_reg); end
    $display("threshold frame: ch=2 done");
    wait_idle(ok);
  endtask

  task automatic test_timeout();
    bit ok;
    tick();
    set_ch(1, 16'd10, 1'b0);
    for (int i = 0; i < 50; i++) tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL to_early: got busy=%b want 0", busy); end
    tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL to_req: got busy=%b want 1", busy); end
    wait_start(ok);
    n_vec++; if (!ok || active_ch !== 3'd1) begin n_err++; $display("FAIL to_grant: got ch=%0d ok=%b want 1", active_ch, ok); end
    n_vec++; if (drv_frame_cnt !== 16'd2) begin n_err++; $display("FAIL to_fcnt: got %0d want 2", drv_frame_cnt); end
    tick();
    n_vec++; if (dut.gen_ch[1].age_reg !== 20'd0) begin n_err++; $display("FAIL to_age_clr: got %0d want 0", dut.gen_ch[1].age_reg); end
    ch_empty[1] = 1'b1;
    tick(); tick();
    drv_send_done = 1'b1;
    tick();
    drv_send_done = 1'b0;
    $display("timeout frame: ch=1 done");
    wait_idle(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL to_idle: got busy, want idle"); end
  endtask

  task automatic test_busy_mux();
    bit ok;
    ch_din = {8'h3C, 8'h2B, 8'h1A, 8'h09};
    set_ch(3, 16'd1008, 1'b0);
    wait_start(ok);
    n_vec++; if (!ok || active_ch !== 3'd3) begin n_err++; $display("FAIL mux_grant: got ch=%0d ok=%b want 3", active_ch, ok); end
    tick();
    drv_send_done = 1'b1;
    drv_rd_en = 1'b1;
    #1;
    n_vec++; if (ch_rd_en !== 4'b1000) begin n_err++; $display("FAIL mux_rd_en: got %b want 1000", ch_rd_en); end
    n_vec++; if (drv_din !== 8'h3C) begin n_err++; $display("FAIL mux_din: got %h want 3c", drv_din); end
    tick();
    drv_send_done = 1'b0;
    #1;
    n_vec++; if (ch_rd_en !== 4'b1000) begin n_err++; $display("FAIL mux_early_done: got %b want 1000", ch_rd_en); end
    drv_rd_en = 1'b0;
    #1;
    n_vec++; if (ch_rd_en !== 4'b0000) begin n_err++; $display("FAIL mux_rd_low: got %b want 0000", ch_rd_en); end
    ch_empty[3] = 1'b1;
    tick();
    drv_send_done = 1'b1;
    tick();
    drv_send_done = 1'b0;
    drv_rd_en = 1'b1;
    #1;
    n_vec++; if (ch_rd_en !== 4'b0000 || drv_data_count !== 16'd0 || drv_empty !== 1'b1) begin
      n_err++; $display("FAIL mux_gap: got rd=%b cnt=%0d empty=%b want 0000/0/1", ch_rd_en, drv_data_count, drv_empty);
    end
    drv_rd_en = 1'b0;
    $display("mux frame: ch=3 done");
    wait_idle(ok);
  endtask

  task automatic test_watchdog();
    bit ok;
    set_ch(0, 16'd2000, 1'b0);
    set_ch(1, 16'd2000, 1'b0);
    wait_start(ok);
    n_vec++; if (!ok || active_ch !== 3'd0) begin n_err++; $display("FAIL wd_grant: got ch=%0d ok=%b want 0", active_ch, ok); end
    drv_rd_en = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    n_vec++; if (wdog_err !== 1'b0 || ch_rd_en !== 4'b0001) begin n_err++; $display("FAIL wd_before: got err=%b rd=%b want 0/0001", wdog_err, ch_rd_en); end
    tick();
    n_vec++; if (wdog_err !== 1'b1 || ch_rd_en !== 4'b0000) begin n_err++; $display("FAIL wd_fire: got err=%b rd=%b want 1/0000", wdog_err, ch_rd_en); end
    drv_rd_en = 1'b0;
    n_vec++; if (dut.gen_ch[0].frame_cnt_reg !== 16'd2) begin n_err++; $display("FAIL wd_fcnt0: got %0d want 2", dut.gen_ch[0].frame_cnt_reg); end
    ch_empty[0] = 1'b1;
    wait_start(ok);
    n_vec++; if (!ok || active_ch !== 3'd1) begin n_err++; $display("FAIL wd_next: got ch=%0d ok=%b want 1", active_ch, ok); end
    n_vec++; if (drv_frame_cnt !== 16'd3) begin n_err++; $display("FAIL wd_next_fcnt: got %0d want 3", drv_frame_cnt); end
    ch_empty[1] = 1'b1;
    finish_frame();
    wait_idle(ok);
    n_vec++; if (wdog_err !== 1'b1) begin n_err++; $display("FAIL wd_sticky: got %b want 1", wdog_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_vec++; if (wdog_err !== 1'b0) begin n_err++; $display("FAIL wd_clear: got %b want 0", wdog_err); end
    $display("watchdog: ch0 aborted, ch1 sent, error cleared");
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_ch(2, 16'd1008, 1'b0);
    wait_start(ok);
    tick();
    drv_rd_en = 1'b1;
    #1;
    n_vec++; if (!ok || ch_rd_en !== 4'b0100) begin n_err++; $display("FAIL rm_busy: got rd=%b ok=%b want 0100", ch_rd_en, ok); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0 || ch_rd_en !== 4'b0000 || drv_empty !== 1'b1) begin
      n_err++; $display("FAIL rm_async: got busy=%b rd=%b empty=%b want 0/0000/1", busy, ch_rd_en, drv_empty);
    end
    tick();
    n_vec++; if ((dut.gen_ch[0].frame_cnt_reg | dut.gen_ch[1].frame_cnt_reg |
                  dut.gen_ch[2].frame_cnt_reg | dut.gen_ch[3].frame_cnt_reg) !== 16'd0) begin
      n_err++; $display("FAIL rm_fcnt: got nonzero %0d/%0d/%0d/%0d want 0", dut.gen_ch[0].frame_cnt_reg,
                        dut.gen_ch[1].frame_cnt_reg, dut.gen_ch[2].frame_cnt_reg, dut.gen_ch[3].frame_cnt_reg);
    end
    n_vec++; if (busy !== 1'b0 || active_ch !== 3'd0) begin n_err++; $display("FAIL rm_edge: got busy=%b ch=%0d want 0/0", busy, active_ch); end
    ch_empty = 4'hF;
    drv_rd_en = 1'b0;
    rst_n = 1'b1;
    tick();
    $display("reset mid-frame: returned to idle");
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, want finish within 1 ms");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b1;
    ch_data_count = '0;
    ch_empty      = 4'hF;
    ch_din        = '0;
    drv_send_done = 1'b0;
    drv_rd_en     = 1'b0;
    err_clr       = 1'b0;
    test_reset();
    test_round_robin();
    test_threshold();
    test_timeout();
    test_busy_mux();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
